// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and mode constants for the serial add/subtract engine
package addsub_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational STEP-bit ripple of full adders, exposing the carry into its top bit
module addsub_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a_i,
    input  logic [STEP-1:0] b_i,
    input  logic            cin_i,
    output logic [STEP-1:0] sum_o,
    output logic            cout_o,
    output logic            c_msb_o
);
    logic [STEP:0] c;
    assign c[0] = cin_i;
    for (genvar i = 0; i < STEP; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o  = c[STEP];
    assign c_msb_o = c[STEP-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle WIDTH-bit add/subtract, STEP bits per clock, with start/busy/done and flags
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow,
    output logic             overflow
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, mode_q, mode_d, cy_q, cy_d, bw_q, bw_d, ov_q, ov_d;
    logic [STEP-1:0]  sum;
    logic             cout, c_msb;
    logic [WIDTH-1:0] sh_next;

    addsub_slice #(.STEP(STEP)) u_slice (
        .a_i    (a_q[STEP-1:0]),
        .b_i    (b_q[STEP-1:0]),
        .cin_i  (c_q),
        .sum_o  (sum),
        .cout_o (cout),
        .c_msb_o(c_msb)
    );

    // sum chunks enter at the top so the LSB chunk ends up at bit 0 after N shifts
    assign sh_next = (WIDTH'(sum) << (WIDTH - STEP)) | (sh_q >> STEP);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        mode_d  = mode_q;
        cy_d    = cy_q;
        bw_d    = bw_q;
        ov_d    = ov_q;
        if (state_q == ST_RUN) begin
            a_d   = a_q >> STEP;
            b_d   = b_q >> STEP;
            sh_d  = sh_next;
            c_d   = cout;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_DONE;
                res_d   = sh_next;
                cy_d    = cout;
                bw_d    = (mode_q == MODE_SUB) & ~cout;
                ov_d    = cout ^ c_msb;
            end
        end else if (start) begin
            state_d = ST_RUN;
            a_d     = a;
            b_d     = b ^ {WIDTH{mode}};
            c_d     = mode;
            mode_d  = mode;
            cnt_d   = '0;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            mode_q  <= 1'b0;
            cy_q    <= 1'b0;
            bw_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            cy_q    <= cy_d;
            bw_q    <= bw_d;
            ov_q    <= ov_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = res_q;
    assign carry_out = cy_q;
    assign borrow    = bw_q;
    assign overflow  = ov_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and model-checked vectors for three serial_addsub configurations
module tb_serial_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v[3];
    logic        mode_v[3];
    logic [15:0] a_v[3];
    logic [15:0] b_v[3];
    logic        busy_v[3], done_v[3], cy_v[3], bw_v[3], ov_v[3];
    logic [7:0]  res0, res1;
    logic [15:0] res2;
    logic [15:0] res_v[3];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat[3] = '{8, 2, 8};
    int          wid[3] = '{8, 8, 16};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8), .STEP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]),
        .result(res0), .carry_out(cy_v[0]), .borrow(bw_v[0]), .overflow(ov_v[0])
    );
    serial_addsub #(.WIDTH(8), .STEP(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]),
        .result(res1), .carry_out(cy_v[1]), .borrow(bw_v[1]), .overflow(ov_v[1])
    );
    serial_addsub #(.WIDTH(16), .STEP(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]),
        .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .result(res2), .carry_out(cy_v[2]), .borrow(bw_v[2]), .overflow(ov_v[2])
    );

    assign res_v[0] = {8'h00, res0};
    assign res_v[1] = {8'h00, res1};
    assign res_v[2] = res2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input int k, input logic m, input logic [15:0] x, input logic [15:0] y,
                          output int t0);
        mode_v[k]  = m;
        a_v[k]     = x;
        b_v[k]     = y;
        start_v[k] = 1'b1;
        @(posedge clk) #1;
        start_v[k] = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int k, output int t);
        for (int g = 0; g < 100 && !done_v[k]; g++) @(posedge clk) #1;
        t = cyc;
    endtask

    task automatic check_out(input int k, input string tag, input logic [15:0] er,
                             input logic ecy, input logic ebw, input logic eov);
        check({tag, ".done"}, 32'(done_v[k]), 32'd1);
        check({tag, ".result"}, 32'(res_v[k]), 32'(er));
        check({tag, ".carry"}, 32'(cy_v[k]), 32'(ecy));
        check({tag, ".borrow"}, 32'(bw_v[k]), 32'(ebw));
        check({tag, ".overflow"}, 32'(ov_v[k]), 32'(eov));
    endtask

    task automatic op(input int k, input logic m, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] er, input logic ecy, input logic ebw, input logic eov,
                      input string tag);
        int t0, nb;
        nb = 0;
        launch(k, m, x, y, t0);
        for (int g = 0; g < 100 && !done_v[k]; g++) begin
            nb += int'(busy_v[k]);
            @(posedge clk) #1;
        end
        check({tag, ".latency"}, 32'(cyc - t0), 32'(lat[k]));
        check({tag, ".busy_cycles"}, 32'(nb), 32'(lat[k]));
        check_out(k, tag, er, ecy, ebw, eov);
        @(posedge clk) #1;
        check({tag, ".done_pulse"}, 32'(done_v[k]), 32'd0);
    endtask

    task automatic rnd(input int k);
        logic [16:0] s;
        logic [15:0] mask, x, y, r;
        logic        m, cy, ov, sa, sb, sr;
        int          w;
        w    = wid[k];
        mask = 16'((32'd1 << w) - 1);
        x    = 16'($urandom) & mask;
        y    = 16'($urandom) & mask;
        m    = 1'($urandom);
        s    = m ? ({1'b0, x} + {1'b0, ~y & mask} + 17'd1) : ({1'b0, x} + {1'b0, y});
        r    = s[15:0] & mask;
        cy   = s[w];
        sa   = x[w-1];
        sb   = y[w-1];
        sr   = r[w-1];
        ov   = m ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        op(k, m, x, y, r, cy, m & ~cy, ov, "rand");
    endtask

    initial begin
        int t0, t1, t2;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        #12;
        check("reset.busy", 32'(busy_v[0]), 32'd0);
        check("reset.done", 32'(done_v[0]), 32'd0);
        check("reset.result", 32'(res_v[0]), 32'd0);
        check("reset.flags", {29'd0, cy_v[0], bw_v[0], ov_v[0]}, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;

        op(0, 1'b1, 16'd100, 16'd55, 16'd45, 1'b1, 1'b0, 1'b0, "sub100_55");
        op(0, 1'b1, 16'd55, 16'd100, 16'hD3, 1'b0, 1'b1, 1'b0, "sub55_100");
        op(0, 1'b0, 16'd200, 16'd100, 16'd44, 1'b1, 1'b0, 1'b0, "add200_100");
        op(0, 1'b0, 16'd127, 16'd1, 16'd128, 1'b0, 1'b0, 1'b1, "add127_1");
        op(0, 1'b1, 16'd128, 16'd1, 16'd127, 1'b1, 1'b0, 1'b1, "sub128_1");
        op(0, 1'b1, 16'd77, 16'd77, 16'd0, 1'b1, 1'b0, 1'b0, "sub_eq");
        op(0, 1'b1, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, "sub0_0");
        op(0, 1'b0, 16'd255, 16'd255, 16'd254, 1'b1, 1'b0, 1'b0, "addmax");

        // a start pulse mid-run must neither restart nor re-sample operands
        launch(0, 1'b1, 16'd100, 16'd55, t0);
        @(posedge clk) #1;
        @(posedge clk) #1;
        mode_v[0]  = 1'b0;
        a_v[0]     = 16'd1;
        b_v[0]     = 16'd2;
        start_v[0] = 1'b1;
        @(posedge clk) #1;
        start_v[0] = 1'b0;
        check("ignore.busy", 32'(busy_v[0]), 32'd1);
        wait_done(0, t1);
        check("ignore.latency", 32'(t1 - t0), 32'd8);
        check_out(0, "ignore", 16'd45, 1'b1, 1'b0, 1'b0);
        @(posedge clk) #1;
        check("ignore.idle", 32'(busy_v[0]), 32'd0);

        // back-to-back: start held during the done cycle
        launch(0, 1'b0, 16'd200, 16'd100, t0);
        wait_done(0, t1);
        check_out(0, "b2b1", 16'd44, 1'b1, 1'b0, 1'b0);
        launch(0, 1'b1, 16'd55, 16'd100, t2);
        check("b2b2.busy", 32'(busy_v[0]), 32'd1);
        check("b2b2.hold_result", 32'(res_v[0]), 32'd44);
        wait_done(0, t2);
        check("b2b2.spacing", 32'(t2 - t1), 32'd9);
        check_out(0, "b2b2", 16'hD3, 1'b0, 1'b1, 1'b0);
        @(posedge clk) #1;

        // async reset mid-run
        launch(0, 1'b1, 16'd100, 16'd55, t0);
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy_v[0]), 32'd0);
        check("abort.done", 32'(done_v[0]), 32'd0);
        check("abort.result", 32'(res_v[0]), 32'd0);
        check("abort.flags", {29'd0, cy_v[0], bw_v[0], ov_v[0]}, 32'd0);
        t1 = 0;
        repeat (10) begin
            @(posedge clk) #1;
            t1 += int'(done_v[0]);
        end
        check("abort.no_done", 32'(t1), 32'd0);
        rst_n = 1'b1;
        op(0, 1'b1, 16'd100, 16'd55, 16'd45, 1'b1, 1'b0, 1'b0, "after_abort");

        op(1, 1'b0, 16'd200, 16'd100, 16'd44, 1'b1, 1'b0, 1'b0, "s4_add");
        op(1, 1'b1, 16'd128, 16'd1, 16'd127, 1'b1, 1'b0, 1'b1, "s4_sub");
        op(2, 1'b0, 16'hFFFF, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0, "w16_add");
        op(2, 1'b1, 16'h8000, 16'd1, 16'h7FFF, 1'b1, 1'b0, 1'b1, "w16_sub");
        for (int i = 0; i < 25; i++) rnd(1);
        for (int i = 0; i < 25; i++) rnd(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle add/subtract engine: WIDTH-bit operands, processed STEP bits per clock through a STEP-bit ripple slice of full adders.
- Mode-selectable: A+B or A-B.
- Start/busy/done handshake plus carry, borrow and signed-overflow flags.
- Trades latency for area; the next generation of the team's fixed 4-bit full-adder subtractor, used by datapaths that cannot afford a full-width ripple chain.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of STEP, and WIDTH >= 2.
- STEP, 1, bits processed per clock; N = WIDTH/STEP processing cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- mode  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  final carry. For subtract: 1 = no borrow.
- borrow  output  1  mode & ~carry_out, i.e. unsigned a < b in subtract mode; 0 in add mode.
- overflow  output  1  two's-complement signed overflow of the selected operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, result, carry_out, borrow, overflow all 0; internal operand/shift/carry registers 0.
- States:
  - IDLE: start=1 at an edge -> latch a, mode, and b XOR {WIDTH{mode}}; carry register <= mode; step counter <= 0; -> RUN; busy=1.
  - RUN: each edge, the slice adds the next STEP bits (LSB chunk first) with the carry register. The sum chunk shifts into the result shift register and the carry register updates. Counter increments. On the edge where counter = N-1 -> DONE.
  - DONE: the edge entering DONE loads result, carry_out, borrow and overflow, and sets done=1, busy=0. The next edge clears done. start=1 on that edge is accepted exactly as in IDLE (back-to-back), otherwise -> IDLE.
- Overflow = carry into MSB XOR carry out of MSB. The slice exposes its internal MSB carry for this.
- Latency: start accepted at edge 0; done high in the cycle after edge N. Throughput is one operation per N+1 cycles.
- start while busy=1 is ignored; operands and mode are not re-sampled.
- result and flags hold their values from done until the next DONE entry. They do not change during a subsequent RUN; only internal registers do.
- Reset asserted mid-RUN aborts immediately to reset values; there is no done pulse and no partial result.
- Boundaries:
  - a=b in subtract -> result 0, carry_out 1, borrow 0.
  - 0-0 -> 0, carry_out 1.
  - Max+max add -> result 2^WIDTH-2, carry_out 1.

Decomposition:
- Package addsub_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - MODE_ADD=0, MODE_SUB=1.
- Sub-module addsub_slice (parameter STEP) is a combinational STEP-bit ripple of full adders.
  - Inputs: a chunk, b chunk, cin.
  - Outputs: sum chunk, cout, c_msb (carry into top bit).
- Top level holds the FSM, the counter (width $clog2(N) minimum 1), the shift registers and the flag registers.

Test Plan:
- WIDTH=8, STEP=1, sub, a=100, b=55:
  - busy high for 8 cycles;
  - done after edge 8 with result=45, carry_out=1, borrow=0, overflow=0.
- Sub, a=55, b=100 -> result=8'hD3 (signed -45), borrow=1, carry_out=0, overflow=0.
- Add, a=200, b=100 -> result=44, carry_out=1, overflow=0.
- Signed overflow:
  - add 127+1 -> result=128, overflow=1;
  - sub 128-1 (i.e. -128-1) -> result=127, overflow=1, borrow=0.
- start pulsed with new operands at edge 3 of a run -> ignored; the original result completes unchanged.
- Back-to-back: start held high in the done cycle -> the second operation is accepted, with done again N+1 cycles later.
- rst_n dropped asynchronously mid-RUN -> all outputs 0 immediately, no done pulse; a fresh start afterwards completes correctly.
- Rerun with WIDTH=8, STEP=4 and WIDTH=16, STEP=2 -> done after 2 and 8 cycles respectively.
  - Random a, b, mode (50 operations) checked against a reference model of {carry_out, result} and overflow.
